hir_mem_bank: RTL

HIR_MEM_BANK -- requirements
Module: hir_mem_bank

---
 rtl/hir_mem_bank.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hir_mem_bank.sv
`timescale 1ns/1ps
// Multi-read-port, single-write-port memory bank with a configurable read latency.
// Define HIR_MEM_INIT_EN to fill every word with its own address after reset.
module hir_mem_bank #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       busy,
    output logic                       collision
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [RD_LAT-1:0] vpipe [NUM_RD];
    logic [DATA_W-1:0] dpipe [NUM_RD][RD_LAT];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              hit;

`ifdef HIR_MEM_INIT_EN
    typedef enum logic {INIT, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = busy_q;

    // The init sequence owns the single write port; user writes are dropped meanwhile.
    always_comb begin
        mem_we    = wr_en;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = DATA_W'(init_cnt);
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        mem_we    = wr_en;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p] && wr_en && (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr)) begin
                hit = 1'b1;
            end
        end
        if (busy) begin
            hit = 1'b0;
        end
    end

    // Reading mem with non-blocking writes pending gives read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
            for (int p = 0; p < NUM_RD; p++) begin
                vpipe[p] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    dpipe[p][s] <= '0;
                end
            end
        end else begin
            collision <= hit;
            for (int p = 0; p < NUM_RD; p++) begin
                vpipe[p][0] <= rd_en[p] & ~busy;
                if (rd_en[p] && !busy) begin
                    dpipe[p][0] <= mem[rd_addr[p*ADDR_W +: ADDR_W]];
                end
                for (int s = 1; s < RD_LAT; s++) begin
                    vpipe[p][s] <= vpipe[p][s-1];
                    if (vpipe[p][s-1]) begin
                        dpipe[p][s] <= dpipe[p][s-1];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_out
        assign rd_valid[g]                  = vpipe[g][RD_LAT-1];
        assign rd_data[g*DATA_W +: DATA_W]  = dpipe[g][RD_LAT-1];
    end

endmodule
